// File: rtl/dec_key_pkg.sv
// Shared definitions for the decimal key front end: key count, debouncer states
// and the one-hot qualifier used to reject multi-key presses.
package dec_key_pkg;

   localparam int NUM_KEYS = 10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } key_state_t;

   // True when exactly one key line is set: non-zero and clearing the lowest set bit leaves nothing.
   function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
      return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
   endfunction

endpackage

// File: rtl/dec_key_debouncer_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Each bit is synchronized on its own; the bus is not treated as a coherent word.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_async,
   output logic [WIDTH-1:0] d_sync
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            meta_reg[gi] <= 1'b0;
            sync_reg[gi] <= 1'b0;
         end else begin
            meta_reg[gi] <= d_async[gi];
            sync_reg[gi] <= meta_reg[gi];
         end
      end
   end

   assign d_sync = sync_reg;

endmodule

// File: rtl/dec_key_debouncer.sv
// Decimal key front end: synchronizes and debounces ten key lines and presents a
// clean registered one-hot digit to the BCD encoder, rejecting multi-key presses.
module dec_key_debouncer
   import dec_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] keys_raw,
   output logic [NUM_KEYS-1:0] dec_out,
   output logic                key_valid,
   output logic                key_held,
   output logic                multi_err
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] keys_s;

   key_state_t          state_reg,     state_next;
   logic [CNT_W-1:0]    cnt_reg,       cnt_next;
   logic [NUM_KEYS-1:0] keys_q_reg,    keys_q_next;
   logic [NUM_KEYS-1:0] dec_out_reg,   dec_out_next;
   logic                key_valid_reg, key_valid_next;
   logic                multi_err_reg, multi_err_next;

   sync_2ff #(
      .WIDTH (NUM_KEYS)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_async (keys_raw),
      .d_sync  (keys_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         keys_q_reg    <= '0;
         dec_out_reg   <= '0;
         key_valid_reg <= 1'b0;
         multi_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         keys_q_reg    <= keys_q_next;
         dec_out_reg   <= dec_out_next;
         key_valid_reg <= key_valid_next;
         multi_err_reg <= multi_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      keys_q_next    = keys_q_reg;
      dec_out_next   = dec_out_reg;
      key_valid_next = 1'b0;
      multi_err_next = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (keys_s != '0) begin
               keys_q_next = keys_s;
               cnt_next    = '0;
               state_next  = DEBOUNCE;
            end
         end

         // Bounce and pattern changes are checked before the terminal count so a
         // change on the last cycle restarts the window instead of being accepted.
         DEBOUNCE: begin
            if (keys_s == '0) begin
               state_next = IDLE;
            end else if (keys_s != keys_q_reg) begin
               keys_q_next = keys_s;
               cnt_next    = '0;
            end else if (cnt_reg == CNT_LAST) begin
               if (is_onehot(keys_q_reg)) begin
                  dec_out_next   = keys_q_reg;
                  key_valid_next = 1'b1;
                  state_next     = PRESSED;
               end else begin
                  multi_err_next = 1'b1;
                  cnt_next       = '0;
                  state_next     = RELEASE;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         // Extra keys stacked on the held key are ignored until everything is released.
         PRESSED: begin
            if (keys_s == '0) begin
               dec_out_next = '0;
               cnt_next     = '0;
               state_next   = RELEASE;
            end
         end

         RELEASE: begin
            if (keys_s != '0) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign dec_out   = dec_out_reg;
   assign key_valid = key_valid_reg;
   assign multi_err = multi_err_reg;
   assign key_held  = (state_reg == PRESSED);

endmodule

// File: tb/tb_dec_key_debouncer.sv
// Bench for dec_key_debouncer: directed scenarios plus randomized key traffic,
// checked every cycle against a run-length model of the debounce rules.
module tb_dec_key_debouncer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] keys_raw = '0;
   logic [9:0] dec_out;
   logic       key_valid;
   logic       key_held;
   logic       multi_err;

   always #5 clk = ~clk;

   dec_key_debouncer #(
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .keys_raw  (keys_raw),
      .dec_out   (dec_out),
      .key_valid (key_valid),
      .key_held  (key_held),
      .multi_err (multi_err)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: the synchronizer is a two-deep delay line; acceptance is
   // "D+1 consecutive identical non-zero samples while armed", re-arming needs
   // D consecutive all-zero samples after the press ends.
   logic [9:0] dly1, dly2;
   int         mode;        // 0 armed, 1 pressed, 2 releasing
   logic [9:0] run_val;
   int         run_len;
   int         zero_len;
   logic [9:0] exp_dec;
   logic       exp_valid;
   logic       exp_multi;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      dly1 = '0; dly2 = '0; mode = 0; run_val = '0; run_len = 0; zero_len = 0;
      exp_dec = '0; exp_valid = 1'b0; exp_multi = 1'b0;
   endtask

   task automatic model_edge(input logic [9:0] raw);
      logic [9:0] s;
      s = dly2;
      dly2 = dly1;
      dly1 = raw;
      exp_valid = 1'b0;
      exp_multi = 1'b0;
      case (mode)
         0: begin
            if (s == 0) begin
               run_len = 0;
            end else if (run_len > 0 && s == run_val) begin
               run_len++;
            end else begin
               run_val = s;
               run_len = 1;
            end
            if (run_len == D + 1) begin
               run_len = 0;
               if ($countones(s) == 1) begin
                  mode = 1; exp_dec = s; exp_valid = 1'b1;
               end else begin
                  mode = 2; zero_len = 0; exp_multi = 1'b1;
               end
            end
         end
         1: begin
            if (s == 0) begin
               mode = 2; zero_len = 0; exp_dec = '0;
            end
         end
         default: begin
            if (s != 0) begin
               zero_len = 0;
            end else begin
               zero_len++;
               if (zero_len == D) begin
                  mode = 0; run_len = 0;
               end
            end
         end
      endcase
   endtask

   task automatic check_outputs();
      check_val("dec_out",   16'(dec_out),   16'(exp_dec));
      check_val("key_valid", 16'(key_valid), 16'(exp_valid));
      check_val("multi_err", 16'(multi_err), 16'(exp_multi));
      check_val("key_held",  16'(key_held),  16'(mode == 1));
      if (key_valid) $display("t=%0t key accepted dec_out=%b", $time, dec_out);
      if (multi_err) $display("t=%0t multi-key press rejected", $time);
   endtask

   task automatic step(input logic [9:0] raw);
      keys_raw = raw;
      @(posedge clk);
      if (rst_n) model_edge(raw);
      else       model_reset();
      #1;
      check_outputs();
   endtask

   task automatic hold(input logic [9:0] raw, input int n);
      for (int i = 0; i < n; i++) step(raw);
   endtask

   function automatic int encode(input logic [9:0] v);
      int r = 15;
      for (int i = 0; i < 10; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int first_valid;
      int r;
      int b0, b1;
      logic [9:0] pat;

      model_reset();

      // Key 2 held through reset: outputs stay zero, then a full debounce after release.
      hold(10'b0000000100, 3);
      rst_n = 1'b1;
      first_valid = 0;
      for (int i = 1; i <= 10; i++) begin
         step(10'b0000000100);
         if (key_valid && first_valid == 0) first_valid = i;
      end
      check_val("rst_latency", 16'(first_valid), 16'd7);
      hold('0, 8);

      // Key 5 with a one-sample bounce at cnt=2.
      hold(10'b0000100000, 3);
      hold('0, 1);
      hold(10'b0000100000, 10);
      check_val("bcd_key5", 16'(encode(dec_out)), 16'd5);
      hold('0, 8);

      // Two keys together are rejected, then key 7 is accepted.
      hold(10'b0001100000, 8);
      hold('0, 8);
      hold(10'b0010000000, 8);
      hold('0, 8);

      // Key 9 held, key 3 added on top.
      hold(10'b1000000000, 8);
      hold(10'b1000001000, 6);
      hold('0, 8);

      // Key 1 released with a re-press bounce, then key 2.
      hold(10'b0000000010, 8);
      hold('0, 2);
      hold(10'b0000000010, 1);
      hold('0, 3);
      hold(10'b0000000100, 12);
      hold('0, 8);

      // Asynchronous reset while a key is held.
      hold(10'b0000010000, 8);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("async_dec",   16'(dec_out),   16'd0);
      check_val("async_held",  16'(key_held),  16'd0);
      check_val("async_valid", 16'(key_valid), 16'd0);
      model_reset();
      hold(10'b0000010000, 2);
      rst_n = 1'b1;
      hold('0, 8);

      // Random traffic: idle gaps, single keys, and two-key chords of random length.
      for (int seg = 0; seg < 300; seg++) begin
         r = $urandom_range(0, 9);
         if (r < 4) begin
            pat = '0;
         end else if (r < 8) begin
            pat = '0;
            pat[$urandom_range(0, 9)] = 1'b1;
         end else begin
            b0 = $urandom_range(0, 9);
            b1 = (b0 + $urandom_range(1, 9)) % 10;
            pat = '0;
            pat[b0] = 1'b1;
            pat[b1] = 1'b1;
         end
         hold(pat, $urandom_range(1, 10));
      end
      hold('0, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
